// File: rtl/proc_ctrl_pkg.sv
// Shared types for the processor control unit: state codes, opcodes,
// ALU select values and instruction-field positions.
package proc_ctrl_pkg;

    localparam int DAW_DEF    = 8;
    localparam int RAW_DEF    = 4;
    localparam int STATEW_DEF = 8;

    typedef enum logic [7:0] {
        ST_INIT   = 8'd0,
        ST_FETCH  = 8'd1,
        ST_DECODE = 8'd2,
        ST_LOADA  = 8'd3,
        ST_LOADB  = 8'd4,
        ST_STORE  = 8'd5,
        ST_ADD    = 8'd6,
        ST_SUB    = 8'd7,
        ST_HALT   = 8'd8,
        ST_JMPZ   = 8'd9
    } state_t;

    typedef enum logic [3:0] {
        OP_NOOP  = 4'h0,
        OP_STORE = 4'h1,
        OP_LOAD  = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_HALT  = 4'h5,
        OP_JMPZ  = 4'h6
    } opcode_t;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    localparam int IR_OP_MSB    = 15;
    localparam int IR_OP_LSB    = 12;
    localparam int IR_DADDR_MSB = 11;
    localparam int IR_DADDR_LSB = 4;
    localparam int IR_RA_MSB    = 11;
    localparam int IR_RA_LSB    = 8;
    localparam int IR_RB_MSB    = 7;
    localparam int IR_RB_LSB    = 4;
    localparam int IR_RW_MSB    = 3;
    localparam int IR_RW_LSB    = 0;

    function automatic opcode_t ir_opcode(input logic [15:0] ir);
        return opcode_t'(ir[IR_OP_MSB:IR_OP_LSB]);
    endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// Control-unit <-> datapath bundle: instruction/status in, strobes and
// selects out, plus the state codes exported for the HEX debug display.
interface proc_ctrl_if #(
    parameter int DAW    = proc_ctrl_pkg::DAW_DEF,
    parameter int RAW    = proc_ctrl_pkg::RAW_DEF,
    parameter int STATEW = proc_ctrl_pkg::STATEW_DEF
) ();
    logic [15:0]     IR;
    logic            RF_Rp_zero;
    logic            PC_clr;
    logic            PC_up;
    logic            PC_ld;
    logic            IR_ld;
    logic [DAW-1:0]  D_addr;
    logic            D_wr;
    logic            RF_s;
    logic [RAW-1:0]  RF_W_addr;
    logic            RF_W_en;
    logic [RAW-1:0]  RF_Ra_addr;
    logic [RAW-1:0]  RF_Rb_addr;
    logic [2:0]      ALU_s0;
    logic [STATEW-1:0] State_Out;
    logic [STATEW-1:0] NextState_Out;

    modport master (
        input  IR, RF_Rp_zero,
        output PC_clr, PC_up, PC_ld, IR_ld, D_addr, D_wr, RF_s, RF_W_addr,
               RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, State_Out, NextState_Out
    );

    modport slave (
        output IR, RF_Rp_zero,
        input  PC_clr, PC_up, PC_ld, IR_ld, D_addr, D_wr, RF_s, RF_W_addr,
               RF_W_en, RF_Ra_addr, RF_Rb_addr, ALU_s0, State_Out, NextState_Out
    );
endinterface

// File: rtl/proc_control_unit.sv
// Moore sequencer for the 16-bit processor datapath; one instruction per 3-4 edges.
// Optional JMPZ instruction is enabled by defining PROC_CTRL_JMPZ_EN.
//
// state  | meaning
// Init   | clear PC
// Fetch  | load IR, PC+1
// Decode | pick the execute state from the opcode
// LoadA  | present RAM address, wait out the read latency
// LoadB  | write RAM data into the register file
// Store  | write register to RAM
// Add    | Rd <= Ra + Rb
// Sub    | Rd <= Ra - Rb
// Halt   | idle until reset
// JmpZ   | PC += offset when Ra == 0
module proc_control_unit
    import proc_ctrl_pkg::*;
#(
    parameter int DAW    = DAW_DEF,
    parameter int RAW    = RAW_DEF,
    parameter int STATEW = STATEW_DEF
) (
    input  logic      CLK,
    input  logic      Reset,
    proc_ctrl_if.master bus
);

    state_t  state;
    state_t  state_nxt;
    opcode_t opcode;

    assign opcode = ir_opcode(bus.IR);

    always_ff @(posedge CLK) begin
        if (Reset) state <= ST_INIT;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.PC_clr     = 1'b0;
        bus.PC_up      = 1'b0;
        bus.PC_ld      = 1'b0;
        bus.IR_ld      = 1'b0;
        bus.D_addr     = '0;
        bus.D_wr       = 1'b0;
        bus.RF_s       = 1'b0;
        bus.RF_W_addr  = '0;
        bus.RF_W_en    = 1'b0;
        bus.RF_Ra_addr = '0;
        bus.RF_Rb_addr = '0;
        bus.ALU_s0     = ALU_PASS;

        unique case (state)
            ST_INIT: begin
                bus.PC_clr = 1'b1;
                state_nxt  = ST_FETCH;
            end
            ST_FETCH: begin
                bus.IR_ld = 1'b1;
                bus.PC_up = 1'b1;
                state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_STORE: state_nxt = ST_STORE;
                    OP_LOAD:  state_nxt = ST_LOADA;
                    OP_ADD:   state_nxt = ST_ADD;
                    OP_SUB:   state_nxt = ST_SUB;
                    OP_HALT:  state_nxt = ST_HALT;
`ifdef PROC_CTRL_JMPZ_EN
                    OP_JMPZ:  state_nxt = ST_JMPZ;
`endif
                    default:  state_nxt = ST_FETCH;
                endcase
            end
            // Address and write target are held across both load cycles so the
            // RAM output is stable when the write strobe fires in LoadB.
            ST_LOADA, ST_LOADB: begin
                bus.D_addr    = DAW'(bus.IR[IR_DADDR_MSB:IR_DADDR_LSB]);
                bus.RF_s      = 1'b1;
                bus.RF_W_addr = RAW'(bus.IR[IR_RW_MSB:IR_RW_LSB]);
                bus.RF_W_en   = (state == ST_LOADB);
                state_nxt     = (state == ST_LOADA) ? ST_LOADB : ST_FETCH;
            end
            ST_STORE: begin
                bus.D_addr     = DAW'(bus.IR[IR_DADDR_MSB:IR_DADDR_LSB]);
                bus.RF_Ra_addr = RAW'(bus.IR[IR_RW_MSB:IR_RW_LSB]);
                bus.ALU_s0     = ALU_PASS;
                bus.D_wr       = 1'b1;
                state_nxt      = ST_FETCH;
            end
            ST_ADD, ST_SUB: begin
                bus.RF_Ra_addr = RAW'(bus.IR[IR_RA_MSB:IR_RA_LSB]);
                bus.RF_Rb_addr = RAW'(bus.IR[IR_RB_MSB:IR_RB_LSB]);
                bus.RF_W_addr  = RAW'(bus.IR[IR_RW_MSB:IR_RW_LSB]);
                bus.RF_s       = 1'b0;
                bus.RF_W_en    = 1'b1;
                bus.ALU_s0     = (state == ST_ADD) ? ALU_ADD : ALU_SUB;
                state_nxt      = ST_FETCH;
            end
            ST_HALT: begin
                state_nxt = ST_HALT;
            end
            ST_JMPZ: begin
`ifdef PROC_CTRL_JMPZ_EN
                bus.RF_Ra_addr = RAW'(bus.IR[IR_RA_MSB:IR_RA_LSB]);
                bus.PC_ld      = bus.RF_Rp_zero;
`endif
                state_nxt = ST_FETCH;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase

        if (Reset) state_nxt = ST_INIT;
    end

`ifndef PROC_CTRL_JMPZ_EN
    logic unused_rp_zero;
    assign unused_rp_zero = bus.RF_Rp_zero;
`endif

    assign bus.State_Out     = STATEW'(state);
    assign bus.NextState_Out = STATEW'(state_nxt);

endmodule
